alu_sched: RTL and testbench
============================

// Module: alu_sched
//
// PURPOSE
//  Shares one combinational alu instance among NUM_REQ requesters (e.g. issue slots/RS ports).
//  Round-robin grant per cycle; the granted operands go through the ALU into a
//  one-entry registered output stage. The stage holds a result with requester id and tag
//  until the consumer (CDB/writeback) accepts it. Sits between issue and the writeback arbiter.
//
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  TAG_W    6   width of opaque destination tag carried with each op
//
// PORTS
//  clock          in   1               system clock, all state on rising edge
//  reset_n        in   1               asynchronous, active-low reset
//  req_valid      in   NUM_REQ         requester i presents an op
//  req_ready      out  NUM_REQ         one-hot grant; op i consumed when valid&ready
//  req_opa        in   NUM_REQ x DATA  operand A per requester
//  req_opb        in   NUM_REQ x DATA  operand B per requester
//  req_func       in   NUM_REQ x ALU_FUNC  operation per requester
//  req_tag        in   NUM_REQ x TAG_W tag per requester
//  out_valid      out  1               result stage occupied
//  out_ready      in   1               consumer accepts result when out_valid&out_ready
//  out_result     out  DATA            registered ALU result
//  out_req_id     out  $clog2(NUM_REQ) index of requester that issued the op
//  out_tag        out  TAG_W           tag of the op
//
// BEHAVIOUR
//  - Reset (reset_n=0, async): out_valid=0; out_result/out_tag/out_req_id=0; rr_ptr=0.
//    req_ready=0 while in reset. An in-flight result is discarded; no partial state survives.
//  - can_issue = !out_valid | out_ready (stage empty or draining this cycle).
//  - req_ready is combinational: one-hot, the first valid requester at or after rr_ptr
//    (wrapping NUM_REQ-1 -> 0), gated by can_issue. It is all zero if there are no requests.
//  - req_ready never depends on the same requester's own valid beyond the arbitration; no loop via out_ready->req_ready->req_valid allowed upstream.
//  - On grant of i: stage loads alu(opa_i,opb_i,func_i), tag_i, id=i; out_valid=1 next cycle.
//    rr_ptr <= (i+1) mod NUM_REQ. No grant -> rr_ptr holds.
//  - Latency: exactly 1 cycle grant-to-out_valid. Throughput: 1 op/cycle with out_ready held 1.
//  - out_valid&!out_ready: stage holds; all out_* stable; req_ready=0 (stall).
//  - out_valid&out_ready with a new grant: drain and refill same cycle; out_valid stays 1.
//  - out_valid&out_ready with no grant: out_valid<=0; out_* payload holds last value.
//  - Arithmetic/width: exactly per alu (32-bit DATA, shifts use opb[4:0]); unknown func yields 32'hdeadbeef, passed through unchanged.
//  - Fairness: continuously asserted requester is granted within NUM_REQ grants.
//
// CONFIGURATION
//  `ALU_SCHED_PERF_EN defined: adds output perf_grants[NUM_REQ] (32b each) counting grants per
//    requester. Reset to 0; saturate at 32'hFFFF_FFFF; also adds perf_stall (32b), which counts cycles
//    with any req_valid and can_issue=0.
//  Not defined: ports and counters absent; functional behaviour identical.
//
// STRUCTURE
//  - sys_defs: DATA, ALU_FUNC (existing); add ALU_SCHED_TAG typedef and NUM_ALU_REQ constant.
//  - Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx), purely combinational;
//    reused later by writeback/CDB arbitration.
//  - alu instantiated once on the muxed granted operands; output stage in this module.
//
// TESTING
//  1. Reset with out_valid=1 mid-stall, reset_n low 1 cycle -> out_valid=0, rr_ptr=0, no result emitted.
//  2. Only req1: ADD 5+7 tag=3, out_ready=1 -> next cycle out_valid=1, result=12, id=1, tag=3.
//  3. All 4 valid continuously, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, 1 result/cycle.
//  4. req0 SUB 3-5 with out_ready=0 for 3 cycles -> result=32'hFFFF_FFFE held stable; req_ready=0;
//     accepted on the cycle out_ready=1, next op issued in the same cycle.
//  5. SRA opa=32'h8000_0000 opb=32'h24 -> 32'hF800_0000 (shift 4); SLT -1<1 -> 1; SLTU -> 0.
//  6. PERF_EN: req2 granted 10 times, 5 stalled cycles -> perf_grants[2]=10, perf_stall=5.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: data word, ALU function codes, tag type,
// requester count and the single-cycle ALU evaluation function.
package alu_sched_pkg;

    typedef logic [31:0] DATA;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } ALU_FUNC;

    localparam int  NUM_ALU_REQ     = 4;
    localparam int  ALU_SCHED_TAG_W = 6;
    localparam DATA ALU_BAD_FUNC    = 32'hdead_beef;

    typedef logic [ALU_SCHED_TAG_W-1:0] ALU_SCHED_TAG;

    // Unused encodings produce a recognisable poison value instead of X.
    function automatic DATA alu_compute(input DATA opa, input DATA opb, input ALU_FUNC func);
        case (func)
            ALU_ADD:  alu_compute = opa + opb;
            ALU_SUB:  alu_compute = opa - opb;
            ALU_AND:  alu_compute = opa & opb;
            ALU_OR:   alu_compute = opa | opb;
            ALU_XOR:  alu_compute = opa ^ opb;
            ALU_SLL:  alu_compute = opa << opb[4:0];
            ALU_SRL:  alu_compute = opa >> opb[4:0];
            ALU_SRA:  alu_compute = DATA'($signed(opa) >>> opb[4:0]);
            ALU_SLT:  alu_compute = {31'd0, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_compute = {31'd0, opa < opb};
            default:  alu_compute = ALU_BAD_FUNC;
        endcase
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around; one-hot grant plus its index.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int N = NUM_ALU_REQ
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx,
    output logic                 o_gnt_any
);

    int w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_gnt_any && i_req[w_idx]) begin
                o_gnt_any    = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = ($clog2(N))'(w_idx);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// One ALU shared round-robin among NUM_REQ requesters, feeding a one-entry result stage.
// Optional `ALU_SCHED_PERF_EN adds per-requester grant counters and a stall counter.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_ALU_REQ,
    parameter int TAG_W   = ALU_SCHED_TAG_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  DATA                        req_opa  [NUM_REQ],
    input  DATA                        req_opb  [NUM_REQ],
    input  ALU_FUNC                    req_func [NUM_REQ],
    input  logic [TAG_W-1:0]           req_tag  [NUM_REQ],
    output logic                       out_valid,
    input  logic                       out_ready,
    output DATA                        out_result,
    output logic [$clog2(NUM_REQ)-1:0] out_req_id,
    output logic [TAG_W-1:0]           out_tag
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_grants [NUM_REQ],
    output logic [31:0]                perf_stall
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic             r_out_valid;
    DATA              r_out_result;
    logic [ID_W-1:0]  r_out_req_id;
    logic [TAG_W-1:0] r_out_tag;
    logic [ID_W-1:0]  r_rr_ptr;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic               w_can_issue;
    logic               w_grant;
    logic [ID_W-1:0]    w_next_ptr;
    DATA                w_alu_result;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    // Grant only when the stage is empty or being drained this cycle.
    assign w_can_issue  = !r_out_valid || out_ready;
    assign w_grant      = w_gnt_any && w_can_issue;
    assign req_ready    = w_gnt & {NUM_REQ{w_can_issue && reset_n}};
    assign w_next_ptr   = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    assign w_alu_result = alu_compute(req_opa[w_gnt_idx], req_opb[w_gnt_idx], req_func[w_gnt_idx]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_req_id <= '0;
            r_out_tag    <= '0;
            r_rr_ptr     <= '0;
        end else if (w_grant) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_alu_result;
            r_out_req_id <= w_gnt_idx;
            r_out_tag    <= req_tag[w_gnt_idx];
            r_rr_ptr     <= w_next_ptr;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_req_id = r_out_req_id;
    assign out_tag    = r_out_tag;

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] r_perf_grants [NUM_REQ];
    logic [31:0] r_perf_stall;

    // Saturating counters so long runs never wrap back to small values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_perf_grants[i] <= '0;
            end
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant && w_gnt[i] && r_perf_grants[i] != 32'hFFFF_FFFF) begin
                    r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
                end
            end
            if ((|req_valid) && !w_can_issue && r_perf_stall != 32'hFFFF_FFFF) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_grants = r_perf_grants;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched: reset, round-robin order, stall/drain,
// ALU corner cases and (with `ALU_SCHED_PERF_EN) the perf counters.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    DATA          req_opa  [N];
    DATA          req_opb  [N];
    ALU_FUNC      req_func [N];
    ALU_SCHED_TAG req_tag  [N];
    logic         out_valid;
    logic         out_ready;
    DATA          out_result;
    logic [1:0]   out_req_id;
    ALU_SCHED_TAG out_tag;
`ifdef ALU_SCHED_PERF_EN
    logic [31:0]  perf_grants [N];
    logic [31:0]  perf_stall;
`endif

    int nAsserts = 0;
    int nFail    = 0;

    alu_sched #(.NUM_REQ(N), .TAG_W(ALU_SCHED_TAG_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_func   (req_func),
        .req_tag    (req_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_req_id (out_req_id),
        .out_tag    (out_tag)
`ifdef ALU_SCHED_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input ALU_FUNC f, input DATA a, input DATA b,
                                 input ALU_SCHED_TAG t);
        req_valid     = '0;
        req_valid[idx] = 1'b1;
        req_opa[idx]  = a;
        req_opb[idx]  = b;
        req_func[idx] = f;
        req_tag[idx]  = t;
    endtask

    // Single requester issue with the stage able to accept; checks grant and result.
    task automatic issueOne(input int idx, input ALU_FUNC f, input DATA a, input DATA b,
                            input ALU_SCHED_TAG t, input DATA expRes);
        logic [N-1:0] oneHot;
        oneHot      = '0;
        oneHot[idx] = 1'b1;
        applyStimulus(idx, f, a, b, t);
        #1;
        checkOutput("issue_ready", req_ready, oneHot);
        cycle();
        checkOutput("issue_valid", out_valid, 1'b1);
        checkOutput("issue_result", out_result, expRes);
        checkOutput("issue_id", out_req_id, idx);
        checkOutput("issue_tag", out_tag, t);
        req_valid = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_opa[i]  = '0;
            req_opb[i]  = '0;
            req_func[i] = ALU_ADD;
            req_tag[i]  = '0;
        end

        // Reset state, requests ignored while in reset
        #1;
        checkOutput("rst_ready", req_ready, 4'b0000);
        checkOutput("rst_valid", out_valid, 1'b0);
        cycle();
        checkOutput("rst_result", out_result, 32'h0);
        checkOutput("rst_id", out_req_id, 2'd0);
        checkOutput("rst_tag", out_tag, 6'd0);
        reset_n   = 1'b1;
        req_valid = '0;
        cycle();

        // Single requester ADD, then drain with payload held
        issueOne(1, ALU_ADD, 32'd5, 32'd7, 6'd3, 32'd12);
        cycle();
        checkOutput("drain_valid", out_valid, 1'b0);
        checkOutput("drain_hold_result", out_result, 32'd12);
        checkOutput("drain_hold_tag", out_tag, 6'd3);

        // Fill the stage, stall, then async reset mid-stall
        out_ready = 1'b0;
        issueOne(2, ALU_XOR, 32'hF0F0_0000, 32'h0F0F_FFFF, 6'd5, 32'hFFFF_FFFF);
        cycle();
        checkOutput("stall_valid", out_valid, 1'b1);
        req_valid = 4'b0100;
        reset_n   = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 1'b0);
        checkOutput("async_rst_ready", req_ready, 4'b0000);
        cycle();
        checkOutput("async_rst_result", out_result, 32'h0);
        reset_n   = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        cycle();
        checkOutput("post_rst_valid", out_valid, 1'b0);

        // All requesters valid: grants 0,1,2,3,0 on consecutive cycles
        for (int i = 0; i < N; i++) begin
            req_opa[i]  = 32'(100 + i);
            req_opb[i]  = 32'(i);
            req_func[i] = ALU_ADD;
            req_tag[i]  = ALU_SCHED_TAG'(10 + i);
        end
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            int g;
            logic [N-1:0] oneHot;
            g         = c % N;
            oneHot    = '0;
            oneHot[g] = 1'b1;
            #1;
            checkOutput("rr_ready", req_ready, oneHot);
            cycle();
            checkOutput("rr_valid", out_valid, 1'b1);
            checkOutput("rr_id", out_req_id, g);
            checkOutput("rr_result", out_result, 32'(100 + 2 * g));
            checkOutput("rr_tag", out_tag, 10 + g);
        end
        req_valid = '0;
        cycle();
        checkOutput("rr_drain_valid", out_valid, 1'b0);

        // SUB under backpressure for 3 cycles, then drain+refill same cycle
        out_ready = 1'b0;
        applyStimulus(0, ALU_SUB, 32'd3, 32'd5, 6'd9);
        #1;
        checkOutput("bp_first_ready", req_ready, 4'b0001);
        cycle();
        checkOutput("bp_result", out_result, 32'hFFFF_FFFE);
        applyStimulus(0, ALU_ADD, 32'd1, 32'd1, 6'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp_stall_ready", req_ready, 4'b0000);
            checkOutput("bp_stall_valid", out_valid, 1'b1);
            checkOutput("bp_stall_result", out_result, 32'hFFFF_FFFE);
            checkOutput("bp_stall_tag", out_tag, 6'd9);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", req_ready, 4'b0001);
        cycle();
        checkOutput("bp_refill_valid", out_valid, 1'b1);
        checkOutput("bp_refill_result", out_result, 32'd2);
        checkOutput("bp_refill_tag", out_tag, 6'd7);
        req_valid = '0;
        cycle();
        checkOutput("bp_empty_valid", out_valid, 1'b0);

        // ALU corner cases, back to back
        issueOne(3, ALU_SRA,  32'h8000_0000, 32'h24, 6'd1, 32'hF800_0000);
        issueOne(2, ALU_SLT,  32'hFFFF_FFFF, 32'd1,  6'd2, 32'd1);
        issueOne(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  6'd3, 32'd0);
        issueOne(0, ALU_FUNC'(4'hF), 32'd1, 32'd2,   6'd4, 32'hDEAD_BEEF);
        issueOne(3, ALU_SLL,  32'd1,         32'd33, 6'd5, 32'd2);
        issueOne(2, ALU_SRL,  32'h8000_0000, 32'd4,  6'd6, 32'h0800_0000);
        issueOne(1, ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 6'd7, 32'h0F00_0F00);
        issueOne(0, ALU_OR,   32'hFF00_0000, 32'h0000_00FF, 6'd8, 32'hFF00_00FF);
        cycle();

`ifdef ALU_SCHED_PERF_EN
        // Perf counters: 10 grants to requester 2, then 5 stalled cycles
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        checkOutput("perf_rst_grants2", perf_grants[2], 32'd0);
        checkOutput("perf_rst_stall", perf_stall, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            issueOne(2, ALU_ADD, 32'(k), 32'd1, 6'd2, 32'(k + 1));
        end
        out_ready = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            cycle();
        end
        req_valid = '0;
        cycle();
        checkOutput("perf_grants2", perf_grants[2], 32'd10);
        checkOutput("perf_grants0", perf_grants[0], 32'd0);
        checkOutput("perf_stall", perf_stall, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
